// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a line parser for ASCII "CHn:ddd\n" commands.
// A well-formed line emits a one-cycle cmd_valid with the latched channel and value.
module uart_cmd_rx #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       cmd_valid,
    output logic [2:0] cmd_ch,
    output logic [7:0] cmd_value,
    output logic       cmd_err,
    output logic       frame_err
);
    localparam int BIT_CYCLES  = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_H     = 8'h48;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_7     = 8'h37;
    localparam logic [7:0] ASC_9     = 8'h39;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
    typedef enum logic [2:0] {P_C, P_H, P_N, P_COLON, P_D, P_SKIP} pstate_t;

    rstate_t         rstate_q;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            rx_valid_q;
    logic [7:0]      rx_byte_q;
    logic            frame_err_q;

    pstate_t         pstate_q;
    logic [2:0]      ch_q;
    logic [9:0]      acc_q;
    logic [1:0]      ndig_q;
    logic            cmd_valid_q, cmd_err_q;
    logic [2:0]      cmd_ch_q;
    logic [7:0]      cmd_value_q;

    logic            is_digit;
    assign is_digit = (rx_byte_q >= ASC_0) && (rx_byte_q <= ASC_9);

    // Receiver: start is confirmed at mid-bit, then every bit is sampled at its centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rstate_q    <= R_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_valid_q  <= 1'b0;
            rx_byte_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (rstate_q)
                R_IDLE: begin
                    if (!sync2_q) begin
                        rstate_q  <= R_START;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                R_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q    <= '0;
                        rstate_q <= sync2_q ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rstate_q <= R_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q    <= '0;
                        rstate_q <= R_IDLE;
                        if (sync2_q) begin
                            rx_valid_q <= 1'b1;
                            rx_byte_q  <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // Parser: an error that consumes the '\n' itself ends the line instead of skipping the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q    <= P_C;
            ch_q        <= '0;
            acc_q       <= '0;
            ndig_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ch_q    <= '0;
            cmd_value_q <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            if (frame_err_q) begin
                pstate_q <= P_SKIP;
            end else if (rx_valid_q && rx_byte_q != ASC_CR) begin
                case (pstate_q)
                    P_C: begin
                        if (rx_byte_q == ASC_C) begin
                            pstate_q <= P_H;
                        end else if (rx_byte_q != ASC_LF) begin
                            cmd_err_q <= 1'b1;
                            pstate_q  <= P_SKIP;
                        end
                    end
                    P_H: begin
                        if (rx_byte_q == ASC_H) begin
                            pstate_q <= P_N;
                        end else begin
                            cmd_err_q <= 1'b1;
                            pstate_q  <= (rx_byte_q == ASC_LF) ? P_C : P_SKIP;
                        end
                    end
                    P_N: begin
                        if (rx_byte_q >= ASC_0 && rx_byte_q <= ASC_7) begin
                            ch_q     <= rx_byte_q[2:0];
                            acc_q    <= '0;
                            ndig_q   <= '0;
                            pstate_q <= P_COLON;
                        end else begin
                            cmd_err_q <= 1'b1;
                            pstate_q  <= (rx_byte_q == ASC_LF) ? P_C : P_SKIP;
                        end
                    end
                    P_COLON: begin
                        if (rx_byte_q == ASC_COLON) begin
                            pstate_q <= P_D;
                        end else begin
                            cmd_err_q <= 1'b1;
                            pstate_q  <= (rx_byte_q == ASC_LF) ? P_C : P_SKIP;
                        end
                    end
                    P_D: begin
                        if (is_digit && ndig_q != 2'd3) begin
                            acc_q  <= 10'(acc_q * 10) + {6'd0, rx_byte_q[3:0]};
                            ndig_q <= ndig_q + 2'd1;
                        end else if (rx_byte_q == ASC_LF) begin
                            pstate_q <= P_C;
                            if (ndig_q != 2'd0 && acc_q <= 10'd255) begin
                                cmd_valid_q <= 1'b1;
                                cmd_ch_q    <= ch_q;
                                cmd_value_q <= acc_q[7:0];
                            end else begin
                                cmd_err_q <= 1'b1;
                            end
                        end else begin
                            cmd_err_q <= 1'b1;
                            pstate_q  <= P_SKIP;
                        end
                    end
                    P_SKIP: begin
                        if (rx_byte_q == ASC_LF) pstate_q <= P_C;
                    end
                    default: pstate_q <= P_C;
                endcase
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_ch    = cmd_ch_q;
    assign cmd_value = cmd_value_q;
    assign cmd_err   = cmd_err_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serialises ASCII lines onto uart_rx and compares the strobes
// against a line-level model of the command grammar.
module tb_uart_cmd_rx;
    localparam int CLK_FRE   = 2;
    localparam int UART_RATE = 62500;
    localparam int BIT       = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int HALF      = BIT / 2;
    // Cycles from driving a start bit to the centre of its stop bit, incl. 2-flop sync.
    localparam int NOM       = 2 + HALF + 9 * BIT;
    localparam byte unsigned LF = 8'h0A;
    localparam byte unsigned CR = 8'h0D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       cmd_valid, cmd_err, frame_err;
    logic [2:0] cmd_ch;
    logic [7:0] cmd_value;

    uart_cmd_rx #(.CLK_FRE(CLK_FRE), .UART_RATE(UART_RATE)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_value(cmd_value),
        .cmd_err(cmd_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     kind;   // 1 cmd_valid, 2 cmd_err, 3 frame_err
        int     ch;
        int     val;
        longint cyc;
    } ev_t;

    longint       cyc = 0;
    ev_t          obs_q[$];
    ev_t          exp_q[$];
    byte unsigned tx_b[$];
    bit           tx_ok[$];
    longint       tx_start[$];
    byte unsigned line_q[$];
    int           overlap = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           d;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                obs_q.push_back('{kind: 1, ch: int'(cmd_ch), val: int'(cmd_value), cyc: cyc});
                $display("cyc %0d: cmd_valid ch=%0d value=%0d", cyc, cmd_ch, cmd_value);
            end
            if (cmd_err) begin
                obs_q.push_back('{kind: 2, ch: 0, val: 0, cyc: cyc});
                $display("cyc %0d: cmd_err", cyc);
            end
            if (frame_err) begin
                obs_q.push_back('{kind: 3, ch: 0, val: 0, cyc: cyc});
                $display("cyc %0d: frame_err", cyc);
            end
            if (cmd_valid && cmd_err) overlap <= overlap + 1;
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded 95000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte unsigned b, input bit ok);
        tx_b.push_back(b);
        tx_ok.push_back(ok);
        tx_start.push_back(cyc);
        uart_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cyc(BIT);
        end
        uart_rx = ok;
        wait_cyc(BIT);
        uart_rx = 1'b1;
        if (!ok) wait_cyc(2 * BIT);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic clear_logs();
        obs_q.delete();
        tx_b.delete();
        tx_ok.delete();
        tx_start.delete();
    endtask

    // Grammar model: is the text received so far still a prefix of "CHn:d{0..3}"?
    function automatic bit prefix_ok();
        for (int k = 0; k < line_q.size(); k++) begin
            int c;
            c = int'(line_q[k]);
            if (k == 0 && c != 67) return 1'b0;
            if (k == 1 && c != 72) return 1'b0;
            if (k == 2 && (c < 48 || c > 55)) return 1'b0;
            if (k == 3 && c != 58) return 1'b0;
            if (k >= 4 && (k > 6 || c < 48 || c > 57)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Value of a complete line, or -1 if it has no digits or exceeds 255.
    function automatic int line_value();
        int v;
        v = 0;
        if (line_q.size() < 5) return -1;
        for (int k = 4; k < line_q.size(); k++) v = v * 10 + (int'(line_q[k]) - 48);
        return (v > 255) ? -1 : v;
    endfunction

    function automatic void build_expected();
        bit skip;
        int v;
        skip = 1'b0;
        exp_q.delete();
        line_q.delete();
        for (int i = 0; i < tx_b.size(); i++) begin
            if (!tx_ok[i]) begin
                exp_q.push_back('{kind: 3, ch: 0, val: 0, cyc: tx_start[i] + NOM + 1});
                skip = 1'b1;
                line_q.delete();
            end else if (tx_b[i] == CR) begin
                // carriage returns carry no meaning anywhere
            end else if (tx_b[i] == LF) begin
                if (!skip && line_q.size() > 0) begin
                    v = line_value();
                    if (v >= 0)
                        exp_q.push_back('{kind: 1, ch: int'(line_q[2]) - 48, val: v,
                                          cyc: tx_start[i] + NOM + 2});
                    else
                        exp_q.push_back('{kind: 2, ch: 0, val: 0, cyc: tx_start[i] + NOM + 2});
                end
                skip = 1'b0;
                line_q.delete();
            end else if (!skip) begin
                line_q.push_back(tx_b[i]);
                if (!prefix_ok()) begin
                    exp_q.push_back('{kind: 2, ch: 0, val: 0, cyc: tx_start[i] + NOM + 2});
                    skip = 1'b1;
                end
            end
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_q.size() || i >= exp_q.size()) return i;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].ch != exp_q[i].ch ||
                obs_q[i].val != exp_q[i].val || obs_q[i].cyc < exp_q[i].cyc - 2 ||
                obs_q[i].cyc > exp_q[i].cyc + 2) return i;
        end
        return -1;
    endfunction

    function automatic string ev_at(input bit from_exp, input int idx);
        ev_t e;
        if (from_exp ? (idx >= exp_q.size()) : (idx >= obs_q.size())) return "none";
        e = from_exp ? exp_q[idx] : obs_q[idx];
        return $sformatf("kind%0d ch%0d val%0d at cyc %0d", e.kind, e.ch, e.val, e.cyc);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(4);
        n_checks++;
        if ({cmd_valid, cmd_err, frame_err, cmd_ch, cmd_value} === 14'd0) n_pass++;
        else $display("FAIL reset_outputs: got valid=%0b err=%0b ferr=%0b ch=%0d value=%0d, want all 0",
                      cmd_valid, cmd_err, frame_err, cmd_ch, cmd_value);
        rst = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_basic();
        clear_logs();
        send_str("CH3:128\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL basic_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
        n_checks++;
        if (obs_q.size() == 1 && cmd_ch === 3'd3 && cmd_value === 8'h80) n_pass++;
        else $display("FAIL basic_cmd: got %0d events ch=%0d value=%0d, want 1 event ch=3 value=128",
                      obs_q.size(), cmd_ch, cmd_value);
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_str("CH7:5\r\n");
        n_checks++;
        if (cmd_ch === 3'd7 && cmd_value === 8'd5) n_pass++;
        else $display("FAIL b2b_first: got ch=%0d value=%0d, want ch=7 value=5", cmd_ch, cmd_value);
        send_str("CH0:");
        n_checks++;
        if (cmd_ch === 3'd7 && cmd_value === 8'd5) n_pass++;
        else $display("FAIL b2b_hold: got ch=%0d value=%0d, want ch=7 value=5", cmd_ch, cmd_value);
        send_str("255\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL b2b_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
    endtask

    task automatic test_range_errors();
        clear_logs();
        send_str("CH2:300\nCH1:1234\nCH4:\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL range_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
        n_checks++;
        if (cmd_ch === 3'd0 && cmd_value === 8'd255) n_pass++;
        else $display("FAIL range_hold: got ch=%0d value=%0d, want ch=0 value=255", cmd_ch, cmd_value);
    endtask

    task automatic test_bad_channel();
        clear_logs();
        send_str("CH9:1\nCH6:42\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL badch_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
    endtask

    task automatic test_frame_error();
        clear_logs();
        send_str("CH5:1");
        send_byte("?", 1'b0);
        send_str("\nCH5:10\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL frame_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
        n_checks++;
        if (cmd_ch === 3'd5 && cmd_value === 8'd10) n_pass++;
        else $display("FAIL frame_cmd: got ch=%0d value=%0d, want ch=5 value=10", cmd_ch, cmd_value);
    endtask

    task automatic test_glitch();
        clear_logs();
        uart_rx = 1'b0;
        wait_cyc(HALF - 4);
        uart_rx = 1'b1;
        wait_cyc(3 * BIT);
        n_checks++;
        if (obs_q.size() == 0) n_pass++;
        else $display("FAIL glitch_silent: got %0d events, want 0", obs_q.size());
        send_str("CH2:7\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL glitch_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
    endtask

    task automatic test_reset_midline();
        byte unsigned nine;
        nine = "9";
        clear_logs();
        send_str("CH1:");
        uart_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            uart_rx = nine[i];
            wait_cyc(BIT);
        end
        wait_cyc(HALF);
        rst = 1'b1;
        wait_cyc(2);
        n_checks++;
        if ({cmd_valid, cmd_err, frame_err, cmd_ch, cmd_value} === 14'd0) n_pass++;
        else $display("FAIL midline_reset: got valid=%0b err=%0b ferr=%0b ch=%0d value=%0d, want all 0",
                      cmd_valid, cmd_err, frame_err, cmd_ch, cmd_value);
        uart_rx = 1'b1;
        rst = 1'b0;
        wait_cyc(BIT);
        clear_logs();
        send_str("CH1:9\n");
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1 && cmd_ch === 3'd1 && cmd_value === 8'd9) n_pass++;
        else $display("FAIL midline_recover: idx %0d got %s want %s, ch=%0d value=%0d want 1/9",
                      d, ev_at(0, d), ev_at(1, d), cmd_ch, cmd_value);
    endtask

    task automatic test_random();
        byte unsigned l[$];
        int kind, nd, bad_pos;
        clear_logs();
        for (int n = 0; n < 4; n++) begin
            l.delete();
            kind = int'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) l.push_back(LF);
            l.push_back("C");
            l.push_back((kind == 4) ? "X" : "H");
            l.push_back(8'(48 + ((kind == 1) ? $urandom_range(8, 9) : $urandom_range(0, 7))));
            l.push_back(":");
            nd = (kind == 2) ? 0 : (kind == 3) ? 4 : int'($urandom_range(1, 3));
            repeat (nd) l.push_back(8'(48 + $urandom_range(0, 9)));
            if ($urandom_range(0, 1) == 1) l.push_back(CR);
            l.push_back(LF);
            bad_pos = (kind == 5) ? int'($urandom_range(0, l.size() - 2)) : -1;
            foreach (l[i]) send_byte(l[i], i != bad_pos);
        end
        wait_cyc(2 * BIT);
        build_expected();
        d = first_diff();
        n_checks++;
        if (d == -1) n_pass++;
        else $display("FAIL random_events: idx %0d got %s want %s", d, ev_at(0, d), ev_at(1, d));
        n_checks++;
        if (overlap == 0) n_pass++;
        else $display("FAIL valid_err_overlap: got %0d overlapping cycles, want 0", overlap);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_range_errors();
        test_bad_channel();
        test_frame_error();
        test_glitch();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
